// File: rtl/mem_stage.sv
// MIPS memory stage: EX/MEM latch, data-memory handshake with wait states, branch resolve, writeback regs.
// Optional DMEM_TIMEOUT_EN aborts an access left unacknowledged for TIMEOUT_CYCLES cycles.
//   state  | meaning
//   IDLE   | latch empty or holding a non-memory op
//   ACCESS | memory op latched, request driven, waiting for ack
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic        branch_i,
  input  logic        reg_write_i,
  input  logic        mem_to_reg_i,
  input  logic [31:0] alu_out_i,
  input  logic [31:0] rt_val_i,
  input  logic [4:0]  reg_dst_addr_i,
  input  logic        zero_i,
  input  logic [31:0] pc_branch_i,
  output logic        stall_o,
  output logic        pcsrc_o,
  output logic [31:0] branch_target_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_valid_o,
  output logic        wb_reg_write_o,
  output logic [4:0]  wb_addr_o,
  output logic [31:0] wb_data_o,
  output logic        err_o
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t      state, next_state;
  logic        lat_valid, lat_mem_write, lat_branch, lat_reg_write, lat_mem_to_reg, lat_zero;
  logic [31:0] lat_alu, lat_rt, lat_pc;
  logic [4:0]  lat_dst;
  logic        timeout_hit, done, capture, new_mem, wb_fire;

  // An access finishes on ack, or on timeout when that feature is built in.
  assign done    = ((state == ACCESS) & dmem_ack_i) | timeout_hit;
  assign capture = valid_i & ~stall_o;
  assign new_mem = capture & (mem_read_i | mem_write_i);
  assign wb_fire = ((state == IDLE) & lat_valid) | done;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = new_mem ? ACCESS : IDLE;
      ACCESS:  if (done) next_state = new_mem ? ACCESS : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    stall_o    = (state == ACCESS) & ~done;
    dmem_req_o = (state == ACCESS);
    dmem_we_o  = (state == ACCESS) & lat_mem_write;
  end

  assign dmem_addr_o     = lat_alu;
  assign dmem_wdata_o    = lat_rt;
  assign pcsrc_o         = lat_valid & lat_branch & lat_zero;
  assign branch_target_o = lat_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_valid      <= 1'b0;
      lat_mem_write  <= 1'b0;
      lat_branch     <= 1'b0;
      lat_reg_write  <= 1'b0;
      lat_mem_to_reg <= 1'b0;
      lat_zero       <= 1'b0;
      lat_alu        <= '0;
      lat_rt         <= '0;
      lat_pc         <= '0;
      lat_dst        <= '0;
    end else if (!stall_o) begin
      lat_valid <= valid_i;
      if (capture) begin
        lat_mem_write  <= mem_write_i;
        lat_branch     <= branch_i;
        lat_reg_write  <= reg_write_i;
        lat_mem_to_reg <= mem_to_reg_i;
        lat_zero       <= zero_i;
        lat_alu        <= alu_out_i;
        lat_rt         <= rt_val_i;
        lat_pc         <= pc_branch_i;
        lat_dst        <= reg_dst_addr_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_o     <= 1'b0;
      wb_reg_write_o <= 1'b0;
      wb_addr_o      <= '0;
      wb_data_o      <= '0;
    end else begin
      wb_valid_o <= wb_fire;
      if (wb_fire) begin
        wb_addr_o      <= lat_dst;
        wb_data_o      <= lat_mem_to_reg ? dmem_rdata_i : lat_alu;
        wb_reg_write_o <= lat_reg_write & ~timeout_hit;
      end
    end
  end

`ifdef DMEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;
  logic          err_q;

  // Down-counter reloaded per transaction; terminal count marks the last allowed ACCESS cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= timeout_hit;
      if (new_mem)                           to_cnt <= CW'(TIMEOUT_CYCLES - 1);
      else if (state == ACCESS && to_cnt != '0) to_cnt <= to_cnt - CW'(1);
    end
  end

  assign timeout_hit = (state == ACCESS) & ~dmem_ack_i & (to_cnt == '0);
  assign err_o       = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_hit        = 1'b0;
  assign err_o              = 1'b0;
`endif

endmodule
